bch_scoreboard: RTL and testbench

- Parametrised, self-checking expected-result scoreboard for the BCH encode/decode simulation chain.
- One push port logs the injected error pattern per accepted codeword.
- Three independent check streams compare decoder outputs in order against the logged expectations:
  - errors-present flag
  - error count
  - located-error pattern
- Successor to the fixed 16-entry, single-bit-wrong stack checker. Adds:
  - configurable depth with full/empty distinction
  - per-cause sticky flags
  - saturating counters
  - backpressure

---
 rtl/bch_scoreboard.sv | 179 +++++++++++++++++
 tb/tb_bch_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : bch_scoreboard
// Brief    : Expected-result scoreboard for the BCH encode/decode chain. One
//            push port logs injected error patterns; three independent streams
//            (present / count / pattern) retire them in order and compare.
//            Optional macro BCH_SB_FIRST_FAIL_EN adds first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module bch_scoreboard #(
  parameter int DATA_BITS = 64,
  parameter int ERR_SZ    = 4,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DATA_BITS-1:0]     push_error,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     present_valid,
  input  logic                     present_value,
  input  logic                     count_valid,
  input  logic [ERR_SZ-1:0]        count_value,
  input  logic                     pattern_valid,
  input  logic [DATA_BITS-1:0]     pattern_value,
  output logic                     wrong,
  output logic [4:0]               cause,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [CNT_W-1:0]         words_checked
`ifdef BCH_SB_FIRST_FAIL_EN
  ,
  output logic                     first_fail_valid,
  output logic [CNT_W-1:0]         first_fail_index,
  output logic [DATA_BITS-1:0]     first_fail_expected,
  output logic [DATA_BITS-1:0]     first_fail_actual
`endif
);

  localparam int          c_AW      = $clog2(DEPTH);
  localparam int          c_PW      = c_AW + 1;
  localparam logic [31:0] c_ERR_MAX = (32'd1 << ERR_SZ) - 32'd1;

  logic [DATA_BITS-1:0] r_mem_pat [DEPTH];
  logic [ERR_SZ-1:0]    r_mem_cnt [DEPTH];
  logic [DEPTH-1:0]     r_mem_prs;

  logic [c_PW-1:0]  r_wr_ptr, r_rd_p, r_rd_c, r_rd_t;
  logic [4:0]       r_cause;
  logic [CNT_W-1:0] r_mis_cnt, r_words;

  logic [c_PW-1:0]   w_occ_p, w_occ_c, w_occ_t, w_level;
  logic [31:0]       w_pc_raw;
  logic [ERR_SZ-1:0] w_pc_sat;
  logic              w_push_ok, w_ovf, w_ufl;
  logic              w_do_p, w_do_c, w_do_t;
  logic              w_mis_p, w_mis_c, w_mis_t;
  logic [1:0]        w_nmis;
  logic [CNT_W:0]    w_mis_sum;
  logic [CNT_W-1:0]  w_mis_next;
  logic [4:0]        w_cause_set;

  // Pointers carry one extra wrap bit, so modular subtraction gives occupancy
  // directly and a completely full FIFO is distinguishable from an empty one.
  assign w_occ_p = r_wr_ptr - r_rd_p;
  assign w_occ_c = r_wr_ptr - r_rd_c;
  assign w_occ_t = r_wr_ptr - r_rd_t;

  always_comb begin
    w_level = w_occ_p;
    if (w_occ_c > w_level) w_level = w_occ_c;
    if (w_occ_t > w_level) w_level = w_occ_t;
  end

  assign level = w_level;
  assign full  = (w_level == c_PW'(DEPTH));

  always_comb begin
    w_pc_raw = '0;
    for (int i = 0; i < DATA_BITS; i++) w_pc_raw = w_pc_raw + 32'(push_error[i]);
  end
  assign w_pc_sat = (w_pc_raw > c_ERR_MAX) ? ERR_SZ'(c_ERR_MAX) : w_pc_raw[ERR_SZ-1:0];

  assign w_push_ok = push && !full;
  assign w_ovf     = push && full;

  assign w_do_p = present_valid && (r_rd_p != r_wr_ptr);
  assign w_do_c = count_valid   && (r_rd_c != r_wr_ptr);
  assign w_do_t = pattern_valid && (r_rd_t != r_wr_ptr);
  assign w_ufl  = (present_valid && !w_do_p) || (count_valid && !w_do_c) ||
                  (pattern_valid && !w_do_t);

  // Case-inequality so an X/Z result from the decoder is flagged, not hidden.
  assign w_mis_p = w_do_p && (present_value !== r_mem_prs[r_rd_p[c_AW-1:0]]);
  assign w_mis_c = w_do_c && (count_value   !== r_mem_cnt[r_rd_c[c_AW-1:0]]);
  assign w_mis_t = w_do_t && (pattern_value !== r_mem_pat[r_rd_t[c_AW-1:0]]);

  assign w_nmis      = 2'(w_mis_p) + 2'(w_mis_c) + 2'(w_mis_t);
  assign w_mis_sum   = {1'b0, r_mis_cnt} + (CNT_W+1)'(w_nmis);
  assign w_mis_next  = w_mis_sum[CNT_W] ? '1 : w_mis_sum[CNT_W-1:0];
  assign w_cause_set = {w_mis_t, w_mis_c, w_mis_p, w_ufl, w_ovf};

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_pat[r_wr_ptr[c_AW-1:0]] <= push_error;
      r_mem_cnt[r_wr_ptr[c_AW-1:0]] <= w_pc_sat;
      r_mem_prs[r_wr_ptr[c_AW-1:0]] <= |push_error;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_p   <= '0;
      r_rd_c   <= '0;
      r_rd_t   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_do_p)    r_rd_p   <= r_rd_p + c_PW'(1);
      if (w_do_c)    r_rd_c   <= r_rd_c + c_PW'(1);
      if (w_do_t)    r_rd_t   <= r_rd_t + c_PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause   <= '0;
      r_mis_cnt <= '0;
      r_words   <= '0;
    end else if (clear) begin
      r_cause   <= '0;
      r_mis_cnt <= '0;
      r_words   <= '0;
    end else begin
      r_cause   <= r_cause | w_cause_set;
      r_mis_cnt <= w_mis_next;
      if (w_do_t && (r_words != '1)) r_words <= r_words + CNT_W'(1);
    end
  end

  assign cause          = r_cause;
  assign wrong          = |r_cause;
  assign mismatch_count = r_mis_cnt;
  assign words_checked  = r_words;

`ifdef BCH_SB_FIRST_FAIL_EN
  logic                 r_ff_valid;
  logic [CNT_W-1:0]     r_ff_index;
  logic [DATA_BITS-1:0] r_ff_exp, r_ff_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ff_valid <= 1'b0;
      r_ff_index <= '0;
      r_ff_exp   <= '0;
      r_ff_act   <= '0;
    end else if (clear) begin
      r_ff_valid <= 1'b0;
      r_ff_index <= '0;
      r_ff_exp   <= '0;
      r_ff_act   <= '0;
    end else if (w_mis_t && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_index <= r_words;
      r_ff_exp   <= r_mem_pat[r_rd_t[c_AW-1:0]];
      r_ff_act   <= pattern_value;
    end
  end

  assign first_fail_valid    = r_ff_valid;
  assign first_fail_index    = r_ff_index;
  assign first_fail_expected = r_ff_exp;
  assign first_fail_actual   = r_ff_act;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_scoreboard
// Brief    : Directed + randomized bench for bch_scoreboard (DEPTH=4, CNT_W=4)
//            against a queue-based reference model. Honors BCH_SB_FIRST_FAIL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_scoreboard;
  localparam int DB = 64;
  localparam int ES = 4;
  localparam int DP = 4;
  localparam int CW = 4;
  localparam int c_SAT  = (1 << CW) - 1;
  localparam int c_PSAT = (1 << ES) - 1;

  logic          clk = 1'b0;
  logic          reset_n, clear, push;
  logic [DB-1:0] push_error;
  logic          full;
  logic [2:0]    level;
  logic          present_valid, present_value, count_valid, pattern_valid;
  logic [ES-1:0] count_value;
  logic [DB-1:0] pattern_value;
  logic          wrong;
  logic [4:0]    cause;
  logic [CW-1:0] mismatch_count, words_checked;
`ifdef BCH_SB_FIRST_FAIL_EN
  logic          first_fail_valid;
  logic [CW-1:0] first_fail_index;
  logic [DB-1:0] first_fail_expected, first_fail_actual;
`endif

  always #5 clk = ~clk;

  bch_scoreboard #(.DATA_BITS(DB), .ERR_SZ(ES), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .push_error(push_error),
    .full(full), .level(level), .present_valid(present_valid), .present_value(present_value),
    .count_valid(count_valid), .count_value(count_value), .pattern_valid(pattern_valid),
    .pattern_value(pattern_value), .wrong(wrong), .cause(cause),
    .mismatch_count(mismatch_count), .words_checked(words_checked)
`ifdef BCH_SB_FIRST_FAIL_EN
    , .first_fail_valid(first_fail_valid), .first_fail_index(first_fail_index),
    .first_fail_expected(first_fail_expected), .first_fail_actual(first_fail_actual)
`endif
  );

  // Reference model: every accepted pattern in push order, plus absolute
  // retire counts per stream.
  logic [DB-1:0] hist[$];
  int            wr_n, rd_p, rd_c, rd_t;
  logic [4:0]    m_cause;
  int            m_mis, m_chk;
  bit            m_ffv;
  int            m_ffi;
  logic [DB-1:0] m_ffe, m_ffa;
  int            checks = 0;
  int            failures = 0;

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int m_level();
    return max3(wr_n - rd_p, wr_n - rd_c, wr_n - rd_t);
  endfunction

  function automatic int sat_pc(logic [DB-1:0] v);
    int n = $countones(v);
    return (n > c_PSAT) ? c_PSAT : n;
  endfunction

  task automatic model_reset();
    hist.delete();
    wr_n = 0; rd_p = 0; rd_c = 0; rd_t = 0;
    m_cause = '0; m_mis = 0; m_chk = 0;
    m_ffv = 0; m_ffi = 0; m_ffe = '0; m_ffa = '0;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("full",     64'(full),           64'(m_level() == DP));
    check("level",    64'(level),          64'(m_level()));
    check("cause",    64'(cause),          64'(m_cause));
    check("wrong",    64'(wrong),          64'(m_cause != 0));
    check("mismatch", 64'(mismatch_count), 64'(m_mis));
    check("words",    64'(words_checked),  64'(m_chk));
`ifdef BCH_SB_FIRST_FAIL_EN
    check("ff_valid", 64'(first_fail_valid),    64'(m_ffv));
    check("ff_index", 64'(first_fail_index),    64'(m_ffi));
    check("ff_exp",   64'(first_fail_expected), m_ffe);
    check("ff_act",   64'(first_fail_actual),   m_ffa);
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // clock the DUT and compare everything.
  task automatic step();
    bit         fullm = (m_level() == DP);
    logic [4:0] nc = '0;
    int         nm = 0;
    bit         chk_inc = 0;
    logic [ES-1:0] ec;
    if (present_valid) begin
      if (rd_p == wr_n) nc[1] = 1'b1;
      else begin
        if (present_value !== (hist[rd_p] != 0)) begin nc[2] = 1'b1; nm++; end
        rd_p++;
      end
    end
    if (count_valid) begin
      if (rd_c == wr_n) nc[1] = 1'b1;
      else begin
        ec = ES'(sat_pc(hist[rd_c]));
        if (count_value !== ec) begin nc[3] = 1'b1; nm++; end
        rd_c++;
      end
    end
    if (pattern_valid) begin
      if (rd_t == wr_n) nc[1] = 1'b1;
      else begin
        if (pattern_value !== hist[rd_t]) begin
          nc[4] = 1'b1; nm++;
          if (!m_ffv) begin
            m_ffv = 1; m_ffi = m_chk; m_ffe = hist[rd_t]; m_ffa = pattern_value;
          end
        end
        chk_inc = 1;
        rd_t++;
      end
    end
    if (push) begin
      if (fullm) nc[0] = 1'b1;
      else begin hist.push_back(push_error); wr_n++; end
    end
    if (clear) begin
      m_cause = '0; m_mis = 0; m_chk = 0;
      m_ffv = 0; m_ffi = 0; m_ffe = '0; m_ffa = '0;
    end else begin
      m_cause = m_cause | nc;
      m_mis = (m_mis + nm > c_SAT) ? c_SAT : m_mis + nm;
      if (chk_inc && m_chk < c_SAT) m_chk++;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic drive(bit ps, logic [DB-1:0] pe, bit pv, bit pval, bit cv,
                       logic [ES-1:0] cval, bit tv, logic [DB-1:0] tval, bit clr);
    push = ps; push_error = pe;
    present_valid = pv; present_value = pval;
    count_valid = cv; count_value = cval;
    pattern_valid = tv; pattern_value = tval;
    clear = clr;
    step();
  endtask

  task automatic idle_inputs();
    push = 0; push_error = '0; present_valid = 0; present_value = 0;
    count_valid = 0; count_value = '0; pattern_valid = 0; pattern_value = '0; clear = 0;
  endtask

  // Reset asserted between edges: outputs must drop before any clock edge.
  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic dpush(logic [DB-1:0] v);
    drive(1, v, 0, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    int k;
    logic [DB-1:0] rv;
    bit ps, pv, cv, tv, pval, clr;
    logic [ES-1:0] cval;
    logic [DB-1:0] pe, tval;

    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;

    // Matching three-entry round trip
    dpush(64'h1); dpush(64'h3); dpush(64'h0);
    drive(0, '0, 1, 1, 1, 4'd1, 1, 64'h1, 0);
    drive(0, '0, 1, 1, 1, 4'd2, 1, 64'h3, 0);
    drive(0, '0, 1, 0, 1, 4'd0, 1, 64'h0, 0);
    check("t1_wrong", 64'(wrong), 64'd0);
    check("t1_words", 64'(words_checked), 64'd3);
    check("t1_level", 64'(level), 64'd0);

    // Fill, then overflow; dropped entry never compared
    do_reset();
    dpush(64'h11); dpush(64'h22); dpush(64'h44); dpush(64'h88);
    check("t2_full", 64'(full), 64'd1);
    check("t2_level", 64'(level), 64'd4);
    dpush(64'hFF);
    check("t2_cause", 64'(cause), 64'h01);
    check("t2_wrong", 64'(wrong), 64'd1);
    drive(0, '0, 1, 1, 1, 4'd2, 1, 64'h11, 0);
    drive(0, '0, 1, 1, 1, 4'd2, 1, 64'h22, 0);
    drive(0, '0, 1, 1, 1, 4'd2, 1, 64'h44, 0);
    drive(0, '0, 1, 1, 1, 4'd2, 1, 64'h88, 0);
    drive(0, '0, 1, 1, 1, 4'd8, 1, 64'hFF, 0);
    check("t2_cause_uf", 64'(cause), 64'h03);
    check("t2_mis", 64'(mismatch_count), 64'd0);

    // Underflow on count stream
    do_reset();
    drive(0, '0, 0, 0, 1, 4'd0, 0, '0, 0);
    check("t3_cause", 64'(cause), 64'h02);
    check("t3_mis", 64'(mismatch_count), 64'd0);

    // Count then pattern mismatch
    do_reset();
    dpush(64'h5);
    drive(0, '0, 0, 0, 1, 4'd3, 0, '0, 0);
    check("t4_cause_c", 64'(cause), 64'h08);
    check("t4_mis1", 64'(mismatch_count), 64'd1);
    drive(0, '0, 0, 0, 0, '0, 1, 64'h4, 0);
    check("t4_cause_t", 64'(cause), 64'h18);
    check("t4_mis2", 64'(mismatch_count), 64'd2);
`ifdef BCH_SB_FIRST_FAIL_EN
    check("t4_ff_idx", 64'(first_fail_index), 64'd0);
    check("t4_ff_exp", first_fail_expected, 64'h5);
    check("t4_ff_act", first_fail_actual, 64'h4);
`endif
    drive(0, '0, 1, 1, 0, '0, 0, '0, 0);

    // Skewed streams: level follows the slowest one
    do_reset();
    dpush(64'h1); dpush(64'h2); dpush(64'h4); dpush(64'h8);
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 1, 0, '0, 0, '0, 0);
    check("t5_full_p", 64'(full), 64'd1);
    for (int i = 0; i < 4; i++) drive(0, '0, 0, 0, 1, 4'd1, 0, '0, 0);
    check("t5_full_c", 64'(full), 64'd1);
    drive(0, '0, 0, 0, 0, '0, 1, 64'h1, 0);
    check("t5_level", 64'(level), 64'd3);
    check("t5_full_t", 64'(full), 64'd0);

    // Clear beats a same-cycle mismatch
    do_reset();
    dpush(64'h7);
    drive(0, '0, 0, 0, 1, 4'd0, 0, '0, 0);
    drive(1, 64'h9, 0, 0, 0, '0, 1, 64'h0, 1);
    check("t6_cause", 64'(cause), 64'd0);
    check("t6_mis", 64'(mismatch_count), 64'd0);
    check("t6_words", 64'(words_checked), 64'd0);
    dpush(64'h3); dpush(64'hC);
    do_reset();

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      ps = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) pe = {$urandom(), $urandom()};
      else begin
        pe = '0;
        k = $urandom_range(0, 6);
        for (int j = 0; j < k; j++) pe[$urandom_range(0, DB-1)] = 1'b1;
      end
      pv = ($urandom_range(0, 2) != 0);
      cv = ($urandom_range(0, 2) != 0);
      tv = ($urandom_range(0, 2) != 0);
      rv = (rd_p < wr_n) ? hist[rd_p] : {$urandom(), $urandom()};
      pval = ($urandom_range(0, 3) != 0) ? (rv != 0) : 1'($urandom());
      rv = (rd_c < wr_n) ? hist[rd_c] : '0;
      cval = ($urandom_range(0, 3) != 0) ? ES'(sat_pc(rv)) : ES'($urandom());
      rv = (rd_t < wr_n) ? hist[rd_t] : '0;
      tval = ($urandom_range(0, 3) != 0) ? rv : (rv ^ (64'h1 << $urandom_range(0, DB-1)));
      clr = ($urandom_range(0, 39) == 0);
      drive(ps, pe, pv, pval, cv, cval, tv, tval, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
